airlock_sequencer: RTL and testbench
====================================

# airlock_sequencer

Upstream control stage for the chamber countdown counter. Sequences the two-door pressure chamber: grants door-open requests only in the safe pressure state, and launches pressurize/depressurize countdowns by issuing a one-cycle `start` pulse with a 10-bit seconds value. It then waits for the counter's `counterDone` before changing chamber state. It is the sole driver of the counter's `start` and `counterSeconds` inputs.

## Interface
- `PRESS_SECONDS`, default 10'd7: countdown length for pressurizing.
- `DEPRESS_SECONDS`, default 10'd8: countdown length for depressurizing.
- `Clock` in 1: single clock; all state changes on rising edge.
- `Reset` in 1: asynchronous, active-low; 0 forces reset state immediately.
- `innerReq` in 1: level; request inner (pressurized-side) door open.
- `outerReq` in 1: level; request outer (vacuum-side) door open.
- `evac` in 1: level, edge-free; request depressurize.
- `press` in 1: level; request pressurize.
- `counterDone` in 1: from counter; high when countdown has reached zero.
- `start` out 1: one-cycle pulse to counter; loads `counterSeconds` and begins count.
- `counterSeconds` out 10: countdown length presented to counter.
- `innerOpen` out 1: inner door open command.
- `outerOpen` out 1: outer door open command.
- `pressurized` out 1: chamber at pressure (stable state, not mid-transition).
- `busy` out 1: countdown in progress (LOAD or WAIT states).

## Operation
- States: PRESS_IDLE, INNER_OPEN, LOAD_DEP, WAIT_DEP, VAC_IDLE, OUTER_OPEN, LOAD_PRS, WAIT_PRS.
- PRESS_IDLE: `innerReq`=1 -> INNER_OPEN; else `evac`=1 -> LOAD_DEP. `innerReq` has priority over `evac`.
- INNER_OPEN: `innerOpen`=1; `innerReq`=0 -> PRESS_IDLE. `evac` is ignored.
- LOAD_DEP: `start`=1, `counterSeconds`=`DEPRESS_SECONDS`; unconditionally -> WAIT_DEP.
- WAIT_DEP: `counterDone`=1 -> VAC_IDLE. All requests are ignored.
- VAC_IDLE: `outerReq`=1 -> OUTER_OPEN; else `press`=1 -> LOAD_PRS. `outerReq` has priority.
- OUTER_OPEN: `outerOpen`=1; `outerReq`=0 -> VAC_IDLE.
- LOAD_PRS: `start`=1, `counterSeconds`=`PRESS_SECONDS`; -> WAIT_PRS.
- WAIT_PRS: `counterDone`=1 -> PRESS_IDLE.
- `innerOpen` and `outerOpen` are never both 1. Neither is 1 in a LOAD or WAIT state.
- `innerReq` in vacuum states and `outerReq` in pressure states are ignored and never latched.
- `evac`/`press` are not queued. A request must still be high when its idle state is sampled.
- `counterDone` is ignored in every state except WAIT_DEP/WAIT_PRS. This includes the LOAD cycle, so a stale done from the previous count is never taken.
- `counterSeconds` is registered. It holds its value from LOAD entry until the next LOAD, and changes only on LOAD entry.

## Timing
- Reset values (during Reset=0 and the first cycle after):
  - state = PRESS_IDLE, `pressurized`=1
  - `start`=0, `busy`=0, `innerOpen`=0, `outerOpen`=0, `counterSeconds`=10'd0
- All outputs are registered; each reflects the state one edge after the causing input is sampled.
- Request to door open: `innerReq` sampled high at edge N -> `innerOpen`=1 after edge N.
- Countdown launch: `evac` sampled at edge N -> `start`=1 for exactly the cycle after N. At the same time `busy`=1, `pressurized`=0, and `counterSeconds`=`DEPRESS_SECONDS`.
- Completion: `counterDone` sampled high in WAIT at edge M -> `busy`=0 after M. `pressurized` updates after M (1 only on WAIT_PRS exit).
- `pressurized` is 0 throughout LOAD_DEP/WAIT_DEP/VAC_IDLE/OUTER_OPEN/LOAD_PRS/WAIT_PRS.
- Reset asserted mid-countdown: immediate return to PRESS_IDLE with reset values. `start` is not re-issued, and the counter is reset by the same `Reset` line.
- `counterDone` held high across the LOAD cycle still completes WAIT on the first WAIT edge. This is accepted behaviour; the counter guarantees done is low after `start`.

## Test plan
- Reset: hold Reset=0 for 2 cycles with all requests high -> `pressurized`=1, doors 0, `start`=0, `counterSeconds`=0; release -> INNER_OPEN next edge (`innerReq` priority).
- Depressurize: from PRESS_IDLE pulse `evac` 1 cycle -> `start` high exactly 1 cycle with `counterSeconds`=7'd8 (default 8); `busy`=1. Assert `counterDone` after 8 cycles -> `busy`=0, `pressurized`=0, VAC_IDLE.
- Door interlock: in WAIT_DEP assert `innerReq` and `outerReq` -> both doors stay 0. After done, `outerReq`=1 -> `outerOpen`=1 with `innerOpen`=0. Drop `outerReq` -> `outerOpen`=0.
- Full cycle: `outerReq` low, `press`=1 in VAC_IDLE -> `start` pulse with `counterSeconds`=7. After `counterDone` -> `pressurized`=1. Then `innerReq` -> `innerOpen`=1.
- Spurious done: pulse `counterDone` in PRESS_IDLE and VAC_IDLE -> no state or output change.
- Reset mid-count: Reset=0 in WAIT_PRS -> `busy`=0, `pressurized`=1 asynchronously, without waiting for the clock. After release, no `start` pulse occurs without a new request.

Source files
------------

// File: rtl/airlock_sequencer.sv
// airlock_sequencer
// Control stage for a two-door pressure chamber. It grants door-open
// requests only in the matching stable pressure state. It also launches
// pressurize and depressurize countdowns on an external counter: it issues
// a one-cycle start pulse together with a 10-bit seconds value, then waits
// for the counter's done flag before it changes the chamber state.
//
// Ports
//   Clock          in   single clock, rising edge
//   Reset          in   asynchronous, active-low
//   innerReq       in   level, request inner (pressurized-side) door open
//   outerReq       in   level, request outer (vacuum-side) door open
//   evac           in   level, request depressurize
//   press          in   level, request pressurize
//   counterDone    in   countdown reached zero (from counter)
//   start          out  one-cycle load/begin pulse to counter
//   counterSeconds out  countdown length presented to counter (held)
//   innerOpen      out  inner door open command
//   outerOpen      out  outer door open command
//   pressurized    out  chamber at pressure, stable state
//   busy           out  countdown in progress (LOAD or WAIT)
//
// Every output is registered. Each output is decoded from the next state
// and loaded into its flop on the same edge as the state register. Because
// of this, an output always agrees with the state that the edge enters.

module airlock_sequencer #(
  parameter logic [9:0] PRESS_SECONDS   = 10'd7,
  parameter logic [9:0] DEPRESS_SECONDS = 10'd8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       innerReq,
  input  logic       outerReq,
  input  logic       evac,
  input  logic       press,
  input  logic       counterDone,
  output logic       start,
  output logic [9:0] counterSeconds,
  output logic       innerOpen,
  output logic       outerOpen,
  output logic       pressurized,
  output logic       busy
);

  localparam int unsigned SEC_W   = 10;
  localparam int unsigned STATE_W = 3;

  // Chamber states
  localparam logic [2:0] PRESS_IDLE = 3'd0;
  localparam logic [2:0] INNER_OPEN = 3'd1;
  localparam logic [2:0] LOAD_DEP   = 3'd2;
  localparam logic [2:0] WAIT_DEP   = 3'd3;
  localparam logic [2:0] VAC_IDLE   = 3'd4;
  localparam logic [2:0] OUTER_OPEN = 3'd5;
  localparam logic [2:0] LOAD_PRS   = 3'd6;
  localparam logic [2:0] WAIT_PRS   = 3'd7;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;

  logic             start_next;
  logic [SEC_W-1:0] seconds_next;
  logic             inner_open_next;
  logic             outer_open_next;
  logic             pressurized_next;
  logic             busy_next;

  // State and registered outputs
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state          <= PRESS_IDLE;
      start          <= 1'b0;
      counterSeconds <= SEC_W'(0);
      innerOpen      <= 1'b0;
      outerOpen      <= 1'b0;
      pressurized    <= 1'b1;
      busy           <= 1'b0;
    end else begin
      state          <= state_next;
      start          <= start_next;
      counterSeconds <= seconds_next;
      innerOpen      <= inner_open_next;
      outerOpen      <= outer_open_next;
      pressurized    <= pressurized_next;
      busy           <= busy_next;
    end
  end

  // Next-state transitions and next-output decode
  always_comb begin
    state_next       = state;
    seconds_next     = counterSeconds;
    start_next       = 1'b0;
    inner_open_next  = 1'b0;
    outer_open_next  = 1'b0;
    pressurized_next = 1'b0;
    busy_next        = 1'b0;

    // Requests meant for the opposite pressure side are never looked at,
    // and counterDone is consulted only in the two WAIT states. This means
    // a stale done that is still high during LOAD cannot end a countdown
    // early.
    case (state)
      PRESS_IDLE: begin
        if (innerReq)  state_next = INNER_OPEN;
        else if (evac) state_next = LOAD_DEP;
      end
      INNER_OPEN: begin
        if (!innerReq) state_next = PRESS_IDLE;
      end
      LOAD_DEP:   state_next = WAIT_DEP;
      WAIT_DEP: begin
        if (counterDone) state_next = VAC_IDLE;
      end
      VAC_IDLE: begin
        if (outerReq)   state_next = OUTER_OPEN;
        else if (press) state_next = LOAD_PRS;
      end
      OUTER_OPEN: begin
        if (!outerReq) state_next = VAC_IDLE;
      end
      LOAD_PRS:   state_next = WAIT_PRS;
      WAIT_PRS: begin
        if (counterDone) state_next = PRESS_IDLE;
      end
      default:    state_next = PRESS_IDLE;
    endcase

    // Outputs for the state being entered. Each door decodes from a single
    // distinct state, so the two doors can never be open together.
    case (state_next)
      PRESS_IDLE: pressurized_next = 1'b1;
      INNER_OPEN: begin
        pressurized_next = 1'b1;
        inner_open_next  = 1'b1;
      end
      OUTER_OPEN: outer_open_next = 1'b1;
      LOAD_DEP, LOAD_PRS: begin
        start_next = 1'b1;
        busy_next  = 1'b1;
      end
      WAIT_DEP, WAIT_PRS: busy_next = 1'b1;
      default: ;
    endcase

    // The seconds value changes only on LOAD entry and is held otherwise
    if (state_next == LOAD_DEP && state != LOAD_DEP) seconds_next = DEPRESS_SECONDS;
    if (state_next == LOAD_PRS && state != LOAD_PRS) seconds_next = PRESS_SECONDS;
  end

endmodule

// File: tb/tb_airlock_sequencer.sv
// Directed bench for airlock_sequencer. Inputs change 1 time unit after
// each rising edge. Outputs are sampled 1 time unit after each rising edge.
module tb_airlock_sequencer;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       innerReq, outerReq, evac, press, counterDone;
  logic       start, innerOpen, outerOpen, pressurized, busy;
  logic [9:0] counterSeconds;

  int checks = 0;
  int errors = 0;

  airlock_sequencer #(
    .PRESS_SECONDS  (10'd7),
    .DEPRESS_SECONDS(10'd8)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .innerReq      (innerReq),
    .outerReq      (outerReq),
    .evac          (evac),
    .press         (press),
    .counterDone   (counterDone),
    .start         (start),
    .counterSeconds(counterSeconds),
    .innerOpen     (innerOpen),
    .outerOpen     (outerOpen),
    .pressurized   (pressurized),
    .busy          (busy)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against one expected tuple
  task automatic expect_all(input string tag, input logic e_start, input logic e_busy,
                            input logic e_press, input logic e_inner, input logic e_outer,
                            input logic [9:0] e_secs);
    check({tag, ".start"},       16'(start),          16'(e_start));
    check({tag, ".busy"},        16'(busy),           16'(e_busy));
    check({tag, ".pressurized"}, 16'(pressurized),    16'(e_press));
    check({tag, ".innerOpen"},   16'(innerOpen),      16'(e_inner));
    check({tag, ".outerOpen"},   16'(outerOpen),      16'(e_outer));
    check({tag, ".seconds"},     16'(counterSeconds), 16'(e_secs));
  endtask

  initial begin
    // Reset with every request high
    Reset = 1'b0;
    innerReq = 1'b1; outerReq = 1'b1; evac = 1'b1; press = 1'b1; counterDone = 1'b1;
    tick(); tick();
    expect_all("reset_held", 0, 0, 1, 0, 0, 10'd0);
    Reset = 1'b1;
    #1;
    expect_all("reset_release", 0, 0, 1, 0, 0, 10'd0);
    tick();
    expect_all("inner_priority", 0, 0, 1, 1, 0, 10'd0);

    // Drop everything: back to PRESS_IDLE
    innerReq = 1'b0; outerReq = 1'b0; evac = 1'b0; press = 1'b0; counterDone = 1'b0;
    tick();
    expect_all("press_idle", 0, 0, 1, 0, 0, 10'd0);

    // Depressurize: evac pulse for one cycle
    evac = 1'b1;
    tick();
    expect_all("load_dep", 1, 1, 0, 0, 0, 10'd8);
    evac = 1'b0;
    tick();
    expect_all("wait_dep0", 0, 1, 0, 0, 0, 10'd8);
    // Door requests during the countdown are ignored
    innerReq = 1'b1; outerReq = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_all($sformatf("wait_dep_interlock%0d", i), 0, 1, 0, 0, 0, 10'd8);
    end
    innerReq = 1'b0; outerReq = 1'b0;
    tick();
    expect_all("wait_dep_last", 0, 1, 0, 0, 0, 10'd8);
    counterDone = 1'b1;
    tick();
    expect_all("vac_idle", 0, 0, 0, 0, 0, 10'd8);
    counterDone = 1'b0;

    // Outer door opens with innerReq also high; innerReq is ignored
    outerReq = 1'b1; innerReq = 1'b1;
    tick();
    expect_all("outer_open", 0, 0, 0, 0, 1, 10'd8);
    innerReq = 1'b0;
    // press while the door is open is ignored
    press = 1'b1;
    tick();
    expect_all("outer_hold", 0, 0, 0, 0, 1, 10'd8);
    press = 1'b0; outerReq = 1'b0;
    tick();
    expect_all("outer_close", 0, 0, 0, 0, 0, 10'd8);

    // Spurious done in VAC_IDLE
    counterDone = 1'b1;
    tick();
    expect_all("spur_vac", 0, 0, 0, 0, 0, 10'd8);
    counterDone = 1'b0;
    tick();
    expect_all("vac_steady", 0, 0, 0, 0, 0, 10'd8);

    // Pressurize
    press = 1'b1;
    tick();
    expect_all("load_prs", 1, 1, 0, 0, 0, 10'd7);
    press = 1'b0;
    tick();
    expect_all("wait_prs0", 0, 1, 0, 0, 0, 10'd7);
    tick();
    expect_all("wait_prs1", 0, 1, 0, 0, 0, 10'd7);
    counterDone = 1'b1;
    tick();
    expect_all("prs_done", 0, 0, 1, 0, 0, 10'd7);
    counterDone = 1'b0;
    innerReq = 1'b1;
    tick();
    expect_all("inner_after_prs", 0, 0, 1, 1, 0, 10'd7);
    // evac is ignored while the inner door is open
    evac = 1'b1;
    tick();
    expect_all("inner_evac_ignored", 0, 0, 1, 1, 0, 10'd7);
    innerReq = 1'b0; evac = 1'b0;
    tick();
    expect_all("inner_close", 0, 0, 1, 0, 0, 10'd7);

    // Spurious done in PRESS_IDLE
    counterDone = 1'b1;
    tick();
    expect_all("spur_press", 0, 0, 1, 0, 0, 10'd7);
    counterDone = 1'b0;

    // Done held across LOAD: ignored during LOAD, taken on the first WAIT edge
    evac = 1'b1; counterDone = 1'b1;
    tick();
    expect_all("stale_load", 1, 1, 0, 0, 0, 10'd8);
    evac = 1'b0;
    tick();
    expect_all("stale_wait", 0, 1, 0, 0, 0, 10'd8);
    tick();
    expect_all("stale_vac", 0, 0, 0, 0, 0, 10'd8);
    counterDone = 1'b0;

    // Into WAIT_PRS, then reset asynchronously
    press = 1'b1;
    tick();
    expect_all("load_prs2", 1, 1, 0, 0, 0, 10'd7);
    press = 1'b0;
    tick();
    expect_all("wait_prs2", 0, 1, 0, 0, 0, 10'd7);
    #2;
    Reset = 1'b0;
    #1;
    expect_all("async_reset", 0, 0, 1, 0, 0, 10'd0);
    tick();
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_all($sformatf("post_reset%0d", i), 0, 0, 1, 0, 0, 10'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound so that the run always terminates
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
